pc_control: RTL
===============

PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving PC/datapath width; legal range 16..64.
REQ-002 SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0080, giving the exception entry address, truncated to DATA_W.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port pc_write  in  1  unconditional PC update request.
REQ-007 SHALL have port pc_write_cond  in  1  conditional (branch) PC update request.
REQ-008 SHALL have port cond  in  3  branch condition code.
REQ-009 SHALL have port pc_source  in  2  next-PC select: 0 alu_out, 1 addr_reg, 2 jump target, 3 rs_val.
REQ-010 SHALL have ports zero and less  in  1 each  ALU flags.
REQ-011 SHALL have port instr_idx  in  DATA_W-6  jump index field.
REQ-012 SHALL have ports alu_out, addr_reg and rs_val  in  DATA_W each  candidate PC sources.
REQ-013 SHALL have port exc_req  in  1  exception request, level; eret  in  1  return-from-exception.
REQ-014 SHALL have outputs pc_out  DATA_W; epc_out  DATA_W; pc_write_en  1; exc_ack  1; br_taken_cnt  16; br_nottaken_cnt  16.

Function
REQ-015 SHALL evaluate cond: 0 false, 1 zero, 2 !zero, 3 !less, 4 less==zero, 5 less!=zero, 6 less, 7 true.
REQ-016 SHALL form the jump target as {pc_out[DATA_W-1:DATA_W-4], instr_idx, 2'b00}.
REQ-017 SHALL drive pc_write_en = pc_write | (pc_write_cond & cond_true), combinationally, in state RUN only; it is 0 in state EXC.
REQ-018 SHALL implement FSM states RUN and EXC; RUN is the reset state.
REQ-019 In RUN with exc_req=1 at a clock edge, SHALL load EPC with the current pc_out, leave the PC unchanged, and enter EXC.
REQ-020 In EXC, SHALL load the PC with EXC_VECTOR, assert exc_ack for exactly that cycle, and return to RUN on the next edge.
REQ-021 In RUN with exc_req=0 and eret=1, SHALL load the PC from EPC.
REQ-022 In RUN with exc_req=0, eret=0 and pc_write_en=1, SHALL load the PC from the pc_source mux; otherwise the PC SHALL hold.
REQ-023 Priority SHALL be exc_req > eret > pc_write/pc_write_cond; a suppressed request SHALL have no side effect.
REQ-024 In EXC, exc_req, eret, pc_write and pc_write_cond SHALL be ignored; a still-high exc_req SHALL be re-taken on the first RUN cycle.
REQ-025 SHALL register pc_out and epc_out; an update is visible the cycle after the qualifying edge.

Reset
REQ-026 On rst_n=0, SHALL immediately set pc_out=RESET_PC, epc_out=0, FSM=RUN, exc_ack=0, and both counters to 0.
REQ-027 Reset asserted during EXC SHALL abort the exception; no vector load occurs after reset release.

Configuration
REQ-028 With macro PC_CTRL_BRANCH_STATS_EN defined, SHALL count each RUN-state edge with pc_write_cond=1, exc_req=0 and eret=0 into br_taken_cnt if cond_true, else into br_nottaken_cnt; counters saturate at 16'hFFFF.
REQ-029 Without PC_CTRL_BRANCH_STATS_EN, both counter outputs SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-030 Package pc_ctrl_pkg SHALL hold the cond code constants, pc_source encodings and the FSM state type.
REQ-031 Condition evaluation SHALL be sub-module pc_cond_eval (cond, zero, less -> cond_true), combinational.

Verification
REQ-032 Reset with RESET_PC=32'h100 -> pc_out=32'h100, epc_out=0 and exc_ack=0 during and after reset.
REQ-033 pc_write_cond=1, cond=1, zero=1, pc_source=0, alu_out=32'h40 -> pc_write_en=1; next cycle pc_out=32'h40, br_taken_cnt=1 with macro.
REQ-034 pc_out=32'h1000_0000, pc_write=1, pc_source=2, instr_idx=26'h3 -> next pc_out=32'h1000_000C.
REQ-035 pc_out=32'h200, exc_req=1 with pc_write=1 -> epc_out=32'h200 and PC unchanged; next cycle pc_out=32'h80 with exc_ack=1; then eret=1 -> pc_out=32'h200.
REQ-036 Macro defined, br_nottaken_cnt preloaded to 16'hFFFF, one more not-taken branch -> counter stays 16'hFFFF.
REQ-037 rst_n=0 while in EXC -> next pc_out=RESET_PC, exc_ack=0; no EXC_VECTOR load after release.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared constants and the FSM state type for pc_control.
package pc_ctrl_pkg;
  localparam logic [2:0] COND_FALSE = 3'd0;
  localparam logic [2:0] COND_ZERO  = 3'd1;
  localparam logic [2:0] COND_NZERO = 3'd2;
  localparam logic [2:0] COND_GE    = 3'd3;
  localparam logic [2:0] COND_LEQZ  = 3'd4;
  localparam logic [2:0] COND_LNEZ  = 3'd5;
  localparam logic [2:0] COND_LT    = 3'd6;
  localparam logic [2:0] COND_TRUE  = 3'd7;
  localparam logic [1:0] PCS_ALU  = 2'd0;
  localparam logic [1:0] PCS_ADDR = 2'd1;
  localparam logic [1:0] PCS_JUMP = 2'd2;
  localparam logic [1:0] PCS_RS   = 2'd3;
  typedef enum logic {ST_RUN, ST_EXC} pc_state_t;
endpackage

// File: rtl/pc_cond_eval.sv
// pc_cond_eval: combinational branch condition decode from ALU flags.
module pc_cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       zero,
  input  logic       less,
  output logic       cond_true
);
  always_comb
    cond_true = cond == COND_FALSE ? 1'b0 :
                cond == COND_ZERO  ? zero :
                cond == COND_NZERO ? !zero :
                cond == COND_GE    ? !less :
                cond == COND_LEQZ  ? less == zero :
                cond == COND_LNEZ  ? less != zero :
                cond == COND_LT    ? less :
                cond == COND_TRUE;
endmodule

// File: rtl/pc_control.sv
// pc_control: program counter update, single-level exception/return and optional branch statistics.
// Define PC_CTRL_BRANCH_STATS_EN to build the saturating taken/not-taken branch counters.
module pc_control
  import pc_ctrl_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [63:0]       EXC_VECTOR = 64'h0000_0080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic [2:0]        cond,
  input  logic [1:0]        pc_source,
  input  logic              zero,
  input  logic              less,
  input  logic [DATA_W-7:0] instr_idx,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] addr_reg,
  input  logic [DATA_W-1:0] rs_val,
  input  logic              exc_req,
  input  logic              eret,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] epc_out,
  output logic              pc_write_en,
  output logic              exc_ack,
  output logic [15:0]       br_taken_cnt,
  output logic [15:0]       br_nottaken_cnt
);
  localparam logic [DATA_W-1:0] EXC_VEC = EXC_VECTOR[DATA_W-1:0];
  pc_state_t         state;
  logic              cond_true;
  logic [DATA_W-1:0] jump_tgt;
  logic [DATA_W-1:0] pc_next;
  pc_cond_eval u_cond (.cond(cond), .zero(zero), .less(less), .cond_true(cond_true));
  assign jump_tgt    = {pc_out[DATA_W-1:DATA_W-4], instr_idx, 2'b00};
  assign pc_write_en = state == ST_RUN && (pc_write || (pc_write_cond && cond_true));
  always_comb begin
    pc_next = alu_out;
    case (pc_source)
      PCS_ALU:  pc_next = alu_out;
      PCS_ADDR: pc_next = addr_reg;
      PCS_JUMP: pc_next = jump_tgt;
      PCS_RS:   pc_next = rs_val;
    endcase
  end
  // EXC lasts one cycle; the vector load and exc_ack land together on leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      pc_out  <= RESET_PC;
      epc_out <= '0;
      exc_ack <= 1'b0;
    end else begin
      exc_ack <= state == ST_EXC;
      if (state == ST_EXC) begin
        pc_out <= EXC_VEC;
        state  <= ST_RUN;
      end else if (exc_req) begin
        epc_out <= pc_out;
        state   <= ST_EXC;
      end else if (eret) begin
        pc_out <= epc_out;
      end else if (pc_write_en) begin
        pc_out <= pc_next;
      end
    end
  end
`ifdef PC_CTRL_BRANCH_STATS_EN
  logic br_evt;
  assign br_evt = state == ST_RUN && pc_write_cond && !exc_req && !eret;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_cnt    <= '0;
      br_nottaken_cnt <= '0;
    end else if (br_evt) begin
      if (cond_true && br_taken_cnt != 16'hFFFF) br_taken_cnt <= br_taken_cnt + 16'd1;
      if (!cond_true && br_nottaken_cnt != 16'hFFFF) br_nottaken_cnt <= br_nottaken_cnt + 16'd1;
    end
  end
`else
  assign br_taken_cnt    = '0;
  assign br_nottaken_cnt = '0;
`endif
endmodule
